// File: rtl/axi_txn_throttle.sv
`default_nettype none
// ============================================================================
// Module      : axi_txn_throttle
// Description : Caps outstanding AXI write and read transactions independently
//               and provides a quiesce handshake (block new issue, drain, ack).
//               Only the AW/AR valid/ready pairs are gated, with no added
//               latency. B and R are observed only, to retire transactions.
//
// Ports       : clk_i, rst_ni          clock, async active-low reset
//               slv_aw_*, mst_aw_*      gated AW valid/ready pair
//               slv_ar_*, mst_ar_*      gated AR valid/ready pair
//               mst_b_valid/ready_i     observed write responses
//               mst_r_valid/ready/last  observed read data (last beat retires)
//               quiesce_req_i/ack_o     level request / drained acknowledge
//               wr/rd_outstanding_o     current outstanding counts
//               err_o                   sticky completion-underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module axi_txn_throttle #(
    parameter int MaxWrTxns = 4,
    parameter int MaxRdTxns = 4,
    localparam int c_max_txns = (MaxWrTxns > MaxRdTxns) ? MaxWrTxns : MaxRdTxns,
    localparam int CntWidth   = $clog2(c_max_txns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                slv_aw_valid_i,
    output logic                slv_aw_ready_o,
    output logic                mst_aw_valid_o,
    input  logic                mst_aw_ready_i,
    input  logic                slv_ar_valid_i,
    output logic                slv_ar_ready_o,
    output logic                mst_ar_valid_o,
    input  logic                mst_ar_ready_i,
    input  logic                mst_b_valid_i,
    input  logic                mst_b_ready_i,
    input  logic                mst_r_valid_i,
    input  logic                mst_r_ready_i,
    input  logic                mst_r_last_i,
    input  logic                quiesce_req_i,
    output logic                quiesce_ack_o,
    output logic [CntWidth-1:0] wr_outstanding_o,
    output logic [CntWidth-1:0] rd_outstanding_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] c_max_wr = CntWidth'(MaxWrTxns);
    localparam logic [CntWidth-1:0] c_max_rd = CntWidth'(MaxRdTxns);
    localparam logic [CntWidth-1:0] c_one    = CntWidth'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_QUIESCED = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ack;
    logic                r_err;
    logic [CntWidth-1:0] r_wr_cnt;
    logic [CntWidth-1:0] r_rd_cnt;
    logic                r_aw_committed;
    logic                r_ar_committed;

    logic w_allow_aw;
    logic w_allow_ar;
    logic w_wr_issue;
    logic w_wr_cmpl;
    logic w_rd_issue;
    logic w_rd_cmpl;
    logic w_drained;

    // A request already shown downstream stays admitted regardless of state or
    // count so that valid is never retracted before its handshake.
    assign w_allow_aw = ((r_state == ST_RUN) && (r_wr_cnt < c_max_wr)) || r_aw_committed;
    assign w_allow_ar = ((r_state == ST_RUN) && (r_rd_cnt < c_max_rd)) || r_ar_committed;

    assign mst_aw_valid_o = slv_aw_valid_i & w_allow_aw;
    assign slv_aw_ready_o = mst_aw_ready_i & w_allow_aw;
    assign mst_ar_valid_o = slv_ar_valid_i & w_allow_ar;
    assign slv_ar_ready_o = mst_ar_ready_i & w_allow_ar;

    assign w_wr_issue = mst_aw_valid_o & mst_aw_ready_i;
    assign w_wr_cmpl  = mst_b_valid_i & mst_b_ready_i;
    assign w_rd_issue = mst_ar_valid_o & mst_ar_ready_i;
    assign w_rd_cmpl  = mst_r_valid_i & mst_r_ready_i & mst_r_last_i;

    assign w_drained = (r_wr_cnt == '0) && (r_rd_cnt == '0) &&
                       !r_aw_committed && !r_ar_committed;

    assign quiesce_ack_o    = r_ack;
    assign err_o            = r_err;
    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_RUN;
            r_ack          <= 1'b0;
            r_err          <= 1'b0;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_aw_committed <= 1'b0;
            r_ar_committed <= 1'b0;
        end else begin
            // Set while presented but stalled; the handshake clears it.
            r_aw_committed <= mst_aw_valid_o & ~mst_aw_ready_i;
            r_ar_committed <= mst_ar_valid_o & ~mst_ar_ready_i;

            // Simultaneous issue and completion cancel out.
            if (w_wr_issue && !w_wr_cmpl) begin
                r_wr_cnt <= r_wr_cnt + c_one;
            end else if (w_wr_cmpl && !w_wr_issue) begin
                if (r_wr_cnt == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_wr_cnt <= r_wr_cnt - c_one;
                end
            end

            if (w_rd_issue && !w_rd_cmpl) begin
                r_rd_cnt <= r_rd_cnt + c_one;
            end else if (w_rd_cmpl && !w_rd_issue) begin
                if (r_rd_cnt == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt - c_one;
                end
            end

            // The ack flop follows the next state so it equals (state==QUIESCED).
            case (r_state)
                ST_RUN: begin
                    r_ack <= 1'b0;
                    if (quiesce_req_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!quiesce_req_i) begin
                        r_state <= ST_RUN;
                        r_ack   <= 1'b0;
                    end else if (w_drained) begin
                        r_state <= ST_QUIESCED;
                        r_ack   <= 1'b1;
                    end else begin
                        r_ack   <= 1'b0;
                    end
                end
                ST_QUIESCED: begin
                    if (!quiesce_req_i) begin
                        r_state <= ST_RUN;
                        r_ack   <= 1'b0;
                    end else begin
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_txn_throttle.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_txn_throttle
// Description : Directed self-checking bench for axi_txn_throttle
//               (MaxWrTxns = MaxRdTxns = 4, so counts are 3 bits wide).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_txn_throttle;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       aw_v = 1'b0, aw_r = 1'b0, ar_v = 1'b0, ar_r = 1'b0;
    logic       b_v = 1'b0, b_r = 1'b0, r_v = 1'b0, r_r = 1'b0, r_l = 1'b0;
    logic       qreq = 1'b0;
    logic       slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid;
    logic       ack, err;
    logic [2:0] wr_out, rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_txn_throttle #(
        .MaxWrTxns(4),
        .MaxRdTxns(4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .slv_aw_valid_i  (aw_v),
        .slv_aw_ready_o  (slv_aw_ready),
        .mst_aw_valid_o  (mst_aw_valid),
        .mst_aw_ready_i  (aw_r),
        .slv_ar_valid_i  (ar_v),
        .slv_ar_ready_o  (slv_ar_ready),
        .mst_ar_valid_o  (mst_ar_valid),
        .mst_ar_ready_i  (ar_r),
        .mst_b_valid_i   (b_v),
        .mst_b_ready_i   (b_r),
        .mst_r_valid_i   (r_v),
        .mst_r_ready_i   (r_r),
        .mst_r_last_i    (r_l),
        .quiesce_req_i   (qreq),
        .quiesce_ack_o   (ack),
        .wr_outstanding_o(wr_out),
        .rd_outstanding_o(rd_out),
        .err_o           (err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks happen on the falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        #2;
        chkc("rst_wr", wr_out, 3'd0);
        chkc("rst_rd", rd_out, 3'd0);
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_err", err, 1'b0);
        nxt();
        nxt();
        rst_n = 1'b1;

        // ---------------- write ceiling ----------------
        aw_v = 1'b1;
        aw_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk1("aw_ready_below_limit", slv_aw_ready, 1'b1);
            chkc("wr_count_ramp", wr_out, 3'(i));
            nxt();
        end
        for (int i = 0; i < 2; i++) begin
            mid();
            chk1("aw_ready_at_limit", slv_aw_ready, 1'b0);
            chk1("aw_valid_at_limit", mst_aw_valid, 1'b0);
            chkc("wr_count_at_limit", wr_out, 3'd4);
            nxt();
        end
        // B at the limit does not reopen the gate in the same cycle.
        b_v = 1'b1;
        b_r = 1'b1;
        mid();
        chk1("aw_ready_same_cycle_b", slv_aw_ready, 1'b0);
        nxt();
        b_v = 1'b0;
        b_r = 1'b0;
        mid();
        chkc("wr_count_after_b", wr_out, 3'd3);
        chk1("aw_ready_after_b", slv_aw_ready, 1'b1);
        nxt();
        aw_v = 1'b0;
        mid();
        chkc("wr_count_refilled", wr_out, 3'd4);
        b_v = 1'b1;
        b_r = 1'b1;
        repeat (4) nxt();
        b_v = 1'b0;
        b_r = 1'b0;
        mid();
        chkc("wr_count_drained", wr_out, 3'd0);
        chk1("no_err_after_drain", err, 1'b0);
        nxt();

        // ---------------- read with 3 beats ----------------
        ar_v = 1'b1;
        ar_r = 1'b1;
        nxt();
        ar_v = 1'b0;
        r_v = 1'b1;
        r_r = 1'b1;
        r_l = 1'b0;
        mid();
        chkc("rd_beat1", rd_out, 3'd1);
        nxt();
        mid();
        chkc("rd_beat2", rd_out, 3'd1);
        nxt();
        r_l = 1'b1;
        mid();
        chkc("rd_beat3", rd_out, 3'd1);
        nxt();
        r_v = 1'b0;
        r_l = 1'b0;
        mid();
        chkc("rd_after_last", rd_out, 3'd0);
        // AR and last R in the same cycle at count 1
        ar_v = 1'b1;
        nxt();
        r_v = 1'b1;
        r_l = 1'b1;
        nxt();
        ar_v = 1'b0;
        r_v = 1'b0;
        r_l = 1'b0;
        mid();
        chkc("rd_issue_and_cmpl", rd_out, 3'd1);
        nxt();
        r_v = 1'b1;
        r_l = 1'b1;
        nxt();
        r_v = 1'b0;
        r_l = 1'b0;
        mid();
        chkc("rd_back_to_zero", rd_out, 3'd0);
        nxt();

        // ---------------- committed AW survives quiesce ----------------
        aw_v = 1'b1;
        aw_r = 1'b0;
        qreq = 1'b1;
        mid();
        chk1("aw_valid_presented", mst_aw_valid, 1'b1);
        nxt();
        mid();
        chk1("aw_valid_held_drain1", mst_aw_valid, 1'b1);
        chk1("ack_drain_committed", ack, 1'b0);
        nxt();
        mid();
        chk1("aw_valid_held_drain2", mst_aw_valid, 1'b1);
        aw_r = 1'b1;
        #1;
        chk1("aw_ready_committed", slv_aw_ready, 1'b1);
        nxt();
        mid();
        chkc("wr_count_committed", wr_out, 3'd1);
        chk1("new_aw_blocked_drain", mst_aw_valid, 1'b0);
        chk1("ack_drain_outstanding", ack, 1'b0);
        aw_v = 1'b0;
        aw_r = 1'b0;
        nxt();
        b_v = 1'b1;
        b_r = 1'b1;
        nxt();
        b_v = 1'b0;
        b_r = 1'b0;
        mid();
        chkc("wr_count_zero_drain", wr_out, 3'd0);
        chk1("ack_not_yet", ack, 1'b0);
        nxt();
        mid();
        chk1("ack_after_b", ack, 1'b1);
        qreq = 1'b0;
        nxt();
        mid();
        chk1("ack_dropped", ack, 1'b0);
        nxt();

        // ---------------- idle quiesce, blocked AR ----------------
        qreq = 1'b1;
        mid();
        chk1("idle_ack_cycle0", ack, 1'b0);
        nxt();
        mid();
        chk1("idle_ack_cycle1", ack, 1'b0);
        nxt();
        mid();
        chk1("idle_ack_cycle2", ack, 1'b1);
        ar_v = 1'b1;
        ar_r = 1'b1;
        #1;
        chk1("ar_blocked_quiesced", mst_ar_valid, 1'b0);
        chk1("ar_ready_blocked", slv_ar_ready, 1'b0);
        nxt();
        qreq = 1'b0;
        mid();
        chk1("ack_held_until_edge", ack, 1'b1);
        chk1("ar_still_blocked", mst_ar_valid, 1'b0);
        nxt();
        mid();
        chk1("ack_low_after_release", ack, 1'b0);
        chk1("ar_released", mst_ar_valid, 1'b1);
        nxt();
        ar_v = 1'b0;
        mid();
        chkc("rd_after_release", rd_out, 3'd1);
        r_v = 1'b1;
        r_l = 1'b1;
        nxt();
        r_v = 1'b0;
        r_l = 1'b0;
        mid();
        chkc("rd_zero_again", rd_out, 3'd0);
        nxt();

        // ---------------- underflow ----------------
        mid();
        chk1("err_before_underflow", err, 1'b0);
        nxt();
        b_v = 1'b1;
        b_r = 1'b1;
        nxt();
        b_v = 1'b0;
        b_r = 1'b0;
        mid();
        chk1("err_set", err, 1'b1);
        chkc("wr_stays_zero", wr_out, 3'd0);
        nxt();
        nxt();
        mid();
        chk1("err_sticky", err, 1'b1);
        nxt();

        // ---------------- async reset mid-burst ----------------
        aw_v = 1'b1;
        aw_r = 1'b1;
        ar_v = 1'b1;
        nxt();
        nxt();
        ar_v = 1'b0;
        nxt();
        aw_v = 1'b0;
        aw_r = 1'b0;
        ar_r = 1'b0;
        qreq = 1'b1;
        nxt();
        mid();
        chkc("pre_reset_wr", wr_out, 3'd3);
        chkc("pre_reset_rd", rd_out, 3'd2);
        chk1("pre_reset_ack", ack, 1'b0);
        chk1("pre_reset_err", err, 1'b1);
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        chkc("async_rst_wr", wr_out, 3'd0);
        chkc("async_rst_rd", rd_out, 3'd0);
        chk1("async_rst_ack", ack, 1'b0);
        chk1("async_rst_err", err, 1'b0);
        qreq = 1'b0;
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_txn_throttle.md
Name: axi_txn_throttle

Overview:
- Sits on the core-complex AXI master path, between the CCU output cut and the ID remapper.
- Caps outstanding write and read transactions independently so the remapper's unique-ID and per-ID transaction limits are never oversubscribed.
- Provides a quiesce handshake: new issue is blocked, in-flight traffic drains, then an acknowledge is raised before the CDC source FIFO is reset or the domain is clock-gated.
- Only the AW/AR valid/ready pairs are gated. All other AXI fields and the W/R/B channels bypass the block; B and R are only observed.

Parameters:
- MaxWrTxns, 4, max outstanding write transactions (AW accepted, B not yet received); range 1..255.
- MaxRdTxns, 4, max outstanding read transactions (AR accepted, last R not yet received); range 1..255.
- CntWidth, $clog2(max(MaxWrTxns,MaxRdTxns)+1), counter width (derived, do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_aw_valid_i  in  1  AW valid from the upstream cut
- slv_aw_ready_o  out  1  AW ready to the upstream cut
- mst_aw_valid_o  out  1  AW valid to the remapper
- mst_aw_ready_i  in  1  AW ready from the remapper
- slv_ar_valid_i  in  1  AR valid from upstream
- slv_ar_ready_o  out  1  AR ready to upstream
- mst_ar_valid_o  out  1  AR valid to the remapper
- mst_ar_ready_i  in  1  AR ready from the remapper
- mst_b_valid_i  in  1  observed B valid
- mst_b_ready_i  in  1  observed B ready
- mst_r_valid_i  in  1  observed R valid
- mst_r_ready_i  in  1  observed R ready
- mst_r_last_i  in  1  observed R last
- quiesce_req_i  in  1  level request to drain and hold
- quiesce_ack_o  out  1  drained; no transactions outstanding
- wr_outstanding_o  out  CntWidth  current write count
- rd_outstanding_o  out  CntWidth  current read count
- err_o  out  1  sticky completion-underflow error

Behaviour:
- Reset (async, rst_ni=0): FSM=RUN, both counts=0, committed flags=0, quiesce_ack_o=0, err_o=0.
- All outputs go to these values while rst_ni=0, whatever the other inputs are.
- Gating is zero latency (combinational); there is no added pipeline stage.
- allow_aw = (state==RUN && wr_cnt<MaxWrTxns) || aw_committed.
- mst_aw_valid_o = slv_aw_valid_i & allow_aw.
- slv_aw_ready_o = mst_aw_ready_i & allow_aw.
- AR uses the same equations with rd_cnt, MaxRdTxns and ar_committed.
- AXI valid stability:
  - aw_committed sets when mst_aw_valid_o=1 and mst_aw_ready_i=0.
  - It clears on the AW handshake.
  - Once presented downstream, an AW is never retracted by a quiesce request or a count change.
  - AR uses ar_committed in the same way.
- Write event definitions:
  - Write issue = mst_aw_valid_o & mst_aw_ready_i.
  - Write completion = mst_b_valid_i & mst_b_ready_i.
- Read event definitions:
  - Read issue = mst_ar_valid_o & mst_ar_ready_i.
  - Read completion = mst_r_valid_i & mst_r_ready_i & mst_r_last_i.
  - Non-last R beats do not change rd_cnt.
- Counter update per cycle:
  - Issue only: +1.
  - Completion only: -1.
  - Issue and completion in the same cycle: unchanged.
  - Neither: unchanged.
- Ceiling: a count never exceeds its limit; the gate prevents any issue at the limit.
  - At wr_cnt==MaxWrTxns, a B in the same cycle does not reopen the gate until the next cycle (registered count).
- Underflow: a completion with count==0 and no simultaneous issue leaves the count at 0 and sets err_o. err_o is cleared only by reset.
- FSM states RUN, DRAIN, QUIESCED:
  - RUN -> DRAIN when quiesce_req_i=1.
  - DRAIN -> QUIESCED when wr_cnt==0, rd_cnt==0 and no committed flag is set, all evaluated on the registered values.
  - DRAIN -> RUN if quiesce_req_i drops before drain completes.
  - QUIESCED -> RUN when quiesce_req_i=0.
- quiesce_ack_o = (state==QUIESCED), registered.
  - Minimum request-to-ack latency with nothing outstanding is 2 cycles: one cycle RUN->DRAIN, one cycle DRAIN->QUIESCED.
- In DRAIN and QUIESCED, no new AW/AR is admitted. A committed request still completes and is counted.
- Completions arriving in QUIESCED are counted as underflow errors, since nothing is outstanding.

Test Plan:
- Reset, then 6 back-to-back AWs with B held off (MaxWrTxns=4) -> exactly 4 handshakes; slv_aw_ready_o=0 from the 5th AW; wr_outstanding_o=4. One B -> the 5th AW handshakes the next cycle; count stays 4.
- Read of 3 beats with last on beat 3 -> rd_outstanding_o 1 through beats 1-2, 0 after beat 3. AR and last R in the same cycle at count 1 -> count stays 1.
- AW presented with mst_aw_ready_i=0, quiesce_req_i raised that cycle -> mst_aw_valid_o stays 1 until ready. State is DRAIN. Ack rises 1 cycle after the matching B returns wr_cnt to 0.
- Idle, quiesce_req_i=1 -> quiesce_ack_o=1 on the 2nd rising edge. New AR is blocked (mst_ar_valid_o=0). Drop the request -> ack=0 next cycle; the AR then issues.
- B handshake with wr_cnt=0 -> err_o=1 and persists; wr_outstanding_o stays 0.
- rst_ni asserted mid-burst with counts 3/2 and state DRAIN -> all outputs at their reset values immediately, without waiting for a clock edge.
